// File: rtl/lsu_bus_bridge.sv
// Core data access -> registered req/rsp bus transaction; 4-cycle minimum (valid in cycle 0, ready pulse in cycle 3).
// Core stalls until completion; the request is held until bus_req_ready; a response watchdog turns a hung slave into an error.
module lsu_bus_bridge #(
   parameter int XLEN       = 32,
   parameter int TIMEOUT_W  = 8,
   parameter bit TIMEOUT_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            core_valid,
   input  logic            core_wen,
   input  logic [XLEN-1:0] core_addr,
   input  logic [3:0]      core_wstrb,
   input  logic [XLEN-1:0] core_wdata,
   output logic            core_ready,
   output logic [XLEN-1:0] core_rdata,
   output logic            core_err,
   output logic            bus_req_valid,
   input  logic            bus_req_ready,
   output logic            bus_req_wen,
   output logic [XLEN-1:0] bus_req_addr,
   output logic [3:0]      bus_req_wstrb,
   output logic [XLEN-1:0] bus_req_wdata,
   input  logic            bus_rsp_valid,
   input  logic [XLEN-1:0] bus_rsp_rdata,
   input  logic            bus_rsp_err
);

   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

   typedef struct packed {
      logic            wen;
      logic [XLEN-1:0] addr;
      logic [3:0]      wstrb;
      logic [XLEN-1:0] wdata;
   } req_t;

   localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;
   localparam logic [TIMEOUT_W-1:0] WDOG_ONE = TIMEOUT_W'(1);

   state_t                state_q, state_d;
   req_t                  req_q, req_d;
   logic [XLEN-1:0]       rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
   logic [TIMEOUT_W-1:0]  wdog_inc;
   logic                  wdog_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
      end
   end

   // wdog_inc is the number of RSP cycles including the current one; the
   // timeout fires in the last of 2**TIMEOUT_W-1 cycles so DONE follows it.
   assign wdog_inc = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_ONE;
   assign wdog_hit = TIMEOUT_EN && (wdog_inc == WDOG_MAX);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (core_valid) state_d = REQ;
         REQ:     if (bus_req_ready) state_d = RSP;
         RSP:     if (bus_rsp_valid || wdog_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wdog_d  = wdog_q;
      case (state_q)
         IDLE: begin
            if (core_valid) begin
               req_d.wen   = core_wen;
               req_d.addr  = core_addr;
               req_d.wstrb = core_wen ? core_wstrb : 4'h0;
               req_d.wdata = core_wdata;
            end
         end
         REQ: begin
            if (bus_req_ready) wdog_d = '0;
         end
         RSP: begin
            wdog_d = wdog_inc;
            if (bus_rsp_valid) begin
               rdata_d = req_q.wen ? '0 : bus_rsp_rdata;
               err_d   = bus_rsp_err;
            end else if (wdog_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus_req_valid = (state_q == REQ);
      core_ready    = (state_q == DONE);
      bus_req_wen   = req_q.wen;
      bus_req_addr  = req_q.addr;
      bus_req_wstrb = req_q.wstrb;
      bus_req_wdata = req_q.wdata;
      core_rdata    = rdata_q;
      core_err      = err_q;
   end

endmodule
